// File: rtl/uart_pkg.sv
// Shared UART encodings: parity/baud selects, receiver states, frame length.
// The transmit unit uses the same parity_type and baud_rate meanings.
package uart_pkg;
  localparam int unsigned FRAME_BITS = 11;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  function automatic int unsigned baud_of(input logic [1:0] sel);
    int unsigned r;
    case (sel)
      BAUD_4800:  r = 4800;
      BAUD_9600:  r = 9600;
      BAUD_19200: r = 19200;
      default:    r = 2400;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/baud_gen_rx16.sv
// 16x oversample tick generator; restart zeroes the phase so the first
// tick lands a fixed number of clocks after the detected start edge.
module baud_gen_rx16
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       restart,
  input  logic [1:0] baud_rate,
  output logic       tick
);
  localparam int unsigned DIV_2400  = CLK_FREQ / (baud_of(BAUD_2400)  * 16);
  localparam int unsigned DIV_4800  = CLK_FREQ / (baud_of(BAUD_4800)  * 16);
  localparam int unsigned DIV_9600  = CLK_FREQ / (baud_of(BAUD_9600)  * 16);
  localparam int unsigned DIV_19200 = CLK_FREQ / (baud_of(BAUD_19200) * 16);
  localparam int CW = $clog2(DIV_2400 + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_top;

  always_comb begin
    w_top = CW'(DIV_2400 - 1);
    case (baud_rate)
      BAUD_4800:  w_top = CW'(DIV_4800 - 1);
      BAUD_9600:  w_top = CW'(DIV_9600 - 1);
      BAUD_19200: w_top = CW'(DIV_19200 - 1);
      default:    ;
    endcase
  end

  assign tick = (r_cnt >= w_top) && !restart;

  always_ff @(posedge clock) begin
    if (!reset_n || restart) r_cnt <= '0;
    else if (r_cnt >= w_top) r_cnt <= '0;
    else                     r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/uart_rx_unit.sv
// 16x-oversampling UART receiver for 11-bit frames (start, 8 data LSB first,
// parity slot, stop); delivers the byte with a one-clock done pulse.
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       data_rx,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic [7:0] data_out,
  output logic       active_flag,
  output logic       done_flag,
  output logic       parity_error,
  output logic       stop_error
);
  rx_state_e  r_state, w_state_nxt;
  logic       r_sync1, r_sync2, r_sync_d;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_slot;
  logic [1:0] r_baud;
  logic [7:0] r_data_out;
  logic       r_active, r_done, r_perr, r_serr;
  logic       w_tick, w_fall, w_mid, w_restart, w_go_data, w_shift_en, w_slot_en, w_finish;
  logic       w_chk_en, w_perr;

  baud_gen_rx16 #(.CLK_FREQ(CLK_FREQ)) u_baud (
    .clock     (clock),
    .reset_n   (reset_n),
    .restart   (w_restart),
    .baud_rate (r_baud),
    .tick      (w_tick)
  );

  assign w_fall = r_sync_d & ~r_sync2;
  assign w_mid  = w_tick && (r_tick_cnt == 4'd15);

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_go_data   = 1'b0;
    w_shift_en  = 1'b0;
    w_slot_en   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE:   if (w_fall) begin w_restart = 1'b1; w_state_nxt = START; end
      START:  if (w_tick && r_tick_cnt == 4'd7) begin
                if (!r_sync2) begin w_go_data = 1'b1; w_state_nxt = DATA; end
                else          w_state_nxt = IDLE;
              end
      DATA:   if (w_mid) begin
                w_shift_en = 1'b1;
                if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
              end
      PARITY: if (w_mid) begin w_slot_en = 1'b1; w_state_nxt = STOP; end
      STOP:   if (w_mid) begin w_finish = 1'b1; w_state_nxt = IDLE; end
      default: w_state_nxt = IDLE;
    endcase
  end

  // parity_type is read live here, so mid-frame changes only matter at STOP
  assign w_chk_en = (parity_type == PAR_ODD) || (parity_type == PAR_EVEN);
  assign w_perr   = w_chk_en && (((^r_shift) ^ r_slot) != (parity_type == PAR_ODD));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_sync_d   <= 1'b1;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_slot     <= 1'b0;
      r_baud     <= BAUD_2400;
      r_data_out <= '0;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
      r_perr     <= 1'b0;
      r_serr     <= 1'b0;
    end else begin
      r_sync1  <= data_rx;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
      r_done   <= w_finish;
      if (w_restart) r_baud <= baud_rate;
      // mid-start sits at count 7; restarting at 0 puts later samples at 15
      if (r_state == IDLE || w_go_data) r_tick_cnt <= '0;
      else if (w_tick)                  r_tick_cnt <= r_tick_cnt + 4'd1;
      if (w_go_data)       r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_shift_en) r_shift <= {r_sync2, r_shift[7:1]};
      if (w_slot_en)  r_slot  <= r_sync2;
      if (w_go_data)     r_active <= 1'b1;
      else if (w_finish) r_active <= 1'b0;
      if (w_finish) begin
        r_data_out <= r_shift;
        r_perr     <= w_perr;
        r_serr     <= !r_sync2;
      end
    end
  end

  assign data_out     = r_data_out;
  assign active_flag  = r_active;
  assign done_flag    = r_done;
  assign parity_error = r_perr;
  assign stop_error   = r_serr;
endmodule

// File: doc/uart_rx_unit.md
# uart_rx_unit

UART receiver that deserialises 11-bit frames (start, 8 data LSB-first, parity slot, stop) from the serial line driven by the transmit unit. It oversamples the line at 16x the selected baud rate, validates the start bit, checks parity and stop, and presents a parallel byte with a one-clock completion pulse. It sits opposite the transmit path in the UART pair and shares its `baud_rate` and `parity_type` encodings.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `data_rx`  in  1  asynchronous serial line; idles high.
- `parity_type`  in  2  01 = odd, 10 = even, 00/11 = no check (slot received and ignored).
- `baud_rate`  in  2  00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200.
- `data_out`  out  8  last received byte.
- `active_flag`  out  1  high from validated start bit until frame end.
- `done_flag`  out  1  one-clock pulse when a frame completes.
- `parity_error`  out  1  parity mismatch on last frame.
- `stop_error`  out  1  stop bit sampled low on last frame.

## Operation
- `data_rx` passes through a 2-flop synchroniser; all decisions use the synchronised value.
- Tick divisor = CLK_FREQ / (baud × 16), truncated. Minimum legal divisor is 2.
- `baud_rate` is latched on the falling edge that leaves IDLE and held for the whole frame.
- The tick generator restarts on that edge, giving a fixed sample phase.
- States:
  - IDLE: wait for synchronised falling edge → START.
  - START: at tick 7, line low → DATA, `active_flag` set; line high → IDLE (false start, no flags touched).
  - DATA: sample every 16 ticks at mid-bit, shifting LSB first; after bit 7 → PARITY.
  - PARITY: sample the slot → STOP.
  - STOP: sample the stop bit, then update outputs → IDLE.
- On STOP sample, in the same clock:
  - `data_out` loads the shift register.
  - `parity_error` = (XOR of data ^ slot) != (odd ? 1 : 0); forced 0 when no check is selected.
  - `stop_error` = !stop_sample.
  - `done_flag` pulses.
- Data is delivered even when an error is flagged.
- `data_out`, `parity_error` and `stop_error` hold until the next completed frame.
- On a framing error (stop low), return to IDLE. A new start needs a fresh falling edge, so a held-low line does not re-trigger.
- `parity_type` changes mid-frame are applied at the STOP evaluation only.

## Timing
- Reset values: `data_out` = 0x00, all flags 0, state IDLE, synchroniser flops 1.
- Reset mid-frame aborts to IDLE on the next edge; the partial byte is discarded and no `done_flag` is raised.
- Start-to-sample latency: 2 clocks (synchroniser) + 8 ticks to mid-start.
- `done_flag` asserts 1 clock after the stop mid-sample tick and lasts exactly 1 clock.
- `active_flag` falls in the same cycle `done_flag` rises.
- `active_flag` is low during START qualification.
- A falling edge in the cycle after `done_flag` is accepted, so back-to-back frames need no idle gap.

## Structure
- Package `uart_pkg` holds:
  - the `parity_type` encodings (PAR_NONE, PAR_ODD, PAR_EVEN);
  - the `baud_rate` encodings and baud lookup function;
  - the receiver state enum (IDLE, START, DATA, PARITY, STOP);
  - the frame-length constant of 11.
- Sub-module `baud_gen_rx16` generates the 16x oversample tick.
  - Inputs: `clock`, `reset_n`, `restart`, latched `baud_rate`.
  - Output: `tick`, a one-clock pulse.
- Everything else stays in `uart_rx_unit`: FSM, 4-bit tick counter, 3-bit bit counter, shift register, check logic.

## Test plan
- 9600 baud, parity odd, frame 0xA5 (slot 1, stop 1) → `data_out` = 0xA5, `done_flag` pulses once, both errors 0.
- 19200 baud, parity even, 0x3C with slot forced 1 → `data_out` = 0x3C, `parity_error` = 1, `stop_error` = 0.
- 2400 baud, no parity, 0xFF with stop held low → `stop_error` = 1. Line then returns high; the next frame 0x00 is received cleanly.
- Low glitch of 5 bit-period/16 on an idle line → no `active_flag`, no `done_flag`, outputs unchanged.
- Two back-to-back frames 0x12 then 0x34 at 4800 with zero idle gap → two `done_flag` pulses, `data_out` 0x12 then 0x34.
- `reset_n` low for 1 clock during data bit 4 → all outputs 0 next edge. A following full frame 0x5A is received correctly.
